// File: rtl/systolic_pkg.sv
// Shared constants and FSM state type for the systolic-array operand feeder.
package systolic_pkg;

  localparam int W         = 8;
  localparam int N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter width: must hold 0..3N-3 without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(3 * n - 1);
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Handshake and operand bus between a matrix source/consumer and the feeder.
interface systolic_feeder_if #(
  parameter int N = systolic_pkg::N_DEFAULT,
  parameter int W = systolic_pkg::W
);

  logic               i_start;
  logic [N*N*W-1:0]   i_matA;
  logic [N*N*W-1:0]   i_matB;
  logic               i_ack;
  logic [N*W-1:0]     o_a;
  logic [N*W-1:0]     o_b;
  logic               o_doProcess;
  logic               o_busy;
  logic               o_done;

  modport slave (
    input  i_start, i_matA, i_matB, i_ack,
    output o_a, o_b, o_doProcess, o_busy, o_done
  );

  modport master (
    output i_start, i_matA, i_matB, i_ack,
    input  o_a, o_b, o_doProcess, o_busy, o_done
  );

endinterface

// File: rtl/systolic_feeder.sv
// Captures A and B on start and streams them skewed into an N x N systolic array
// for 3N-2 cycles, then holds the array (zero operands) until acknowledged.
module systolic_feeder #(
  parameter int N = systolic_pkg::N_DEFAULT,
  parameter int W = systolic_pkg::W
) (
  input  logic              i_clk,
  input  logic              i_arst,
  systolic_feeder_if.slave  bus
);

  import systolic_pkg::*;

  localparam int             STEPS  = 3 * N - 2;
  localparam int             CW     = cnt_width(N);
  localparam logic [CW-1:0]  T_LAST = CW'(STEPS - 1);

  state_t           r_state, w_state_next;
  logic [CW-1:0]    r_t, w_t_next;
  logic [N*N*W-1:0] r_mat_a, r_mat_b, w_mat_a_next, w_mat_b_next;
  logic [N*W-1:0]   r_a, r_b, w_a_skew, w_b_skew, w_a_next, w_b_next;
  logic             r_do_process, r_busy, r_done;

  always_comb begin
    w_state_next = r_state;
    w_t_next     = r_t;
    w_mat_a_next = r_mat_a;
    w_mat_b_next = r_mat_b;
    unique case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_state_next = RUN;
          w_t_next     = '0;
          w_mat_a_next = bus.i_matA;
          w_mat_b_next = bus.i_matB;
        end
      end
      RUN: begin
        if (r_t == T_LAST) begin
          w_state_next = DONE;
        end else begin
          w_t_next = r_t + 1'b1;
        end
      end
      DONE: begin
        if (bus.i_ack) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs are registered, so the skew is computed from the next step/matrix
  // values; row i sees A[i][t-i], column j sees B[t-j][j].
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [W-1:0] w_a_row, w_b_col;

    always_comb begin
      w_a_row = '0;
      w_b_col = '0;
      for (int k = 0; k < N; k++) begin
        if (w_t_next == CW'(gi + k)) begin
          w_a_row = w_mat_a_next[(gi*N + k)*W +: W];
          w_b_col = w_mat_b_next[(k*N + gi)*W +: W];
        end
      end
    end

    assign w_a_skew[gi*W +: W] = w_a_row;
    assign w_b_skew[gi*W +: W] = w_b_col;
  end

  assign w_a_next = (w_state_next == RUN) ? w_a_skew : '0;
  assign w_b_next = (w_state_next == RUN) ? w_b_skew : '0;

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_state      <= IDLE;
      r_t          <= '0;
      r_mat_a      <= '0;
      r_mat_b      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_do_process <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_t          <= w_t_next;
      r_mat_a      <= w_mat_a_next;
      r_mat_b      <= w_mat_b_next;
      r_a          <= w_a_next;
      r_b          <= w_b_next;
      r_do_process <= (w_state_next != IDLE);
      r_busy       <= (w_state_next != IDLE);
      r_done       <= (w_state_next == DONE);
    end
  end

  assign bus.o_a         = r_a;
  assign bus.o_b         = r_b;
  assign bus.o_doProcess = r_do_process;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench: drives the feeder into a behavioural 4x4 MAC array and
// scoreboards the skewed operand streams and final array results.
module tb_systolic_feeder;

  localparam int N     = 4;
  localparam int W     = systolic_pkg::W;
  localparam int STEPS = 3 * N - 2;

  logic clk  = 1'b0;
  logic arst = 1'b1;

  systolic_feeder_if #(.N(N), .W(W)) bus ();

  systolic_feeder #(.N(N), .W(W)) dut (
    .i_clk  (clk),
    .i_arst (arst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Behavioural PE array: a flows right, b flows down, acc clears when idle.
  logic [W-1:0] pa [N][N];
  logic [W-1:0] pb [N][N];
  int           acc[N][N];

  function automatic logic [W-1:0] a_in(int i, int j);
    if (j == 0) return bus.o_a[i*W +: W];
    return pa[i][j-1];
  endfunction

  function automatic logic [W-1:0] b_in(int i, int j);
    if (i == 0) return bus.o_b[j*W +: W];
    return pb[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!bus.o_doProcess) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= 0;
        end else begin
          pa[i][j]  <= a_in(i, j);
          pb[i][j]  <= b_in(i, j);
          acc[i][j] <= acc[i][j] + int'(a_in(i, j)) * int'(b_in(i, j));
        end
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [N*W-1:0] q_a[$];
  logic [N*W-1:0] q_b[$];
  int             q_c[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] el(logic [N*N*W-1:0] m, int r, int c);
    return m[(r*N + c)*W +: W];
  endfunction

  function automatic logic [N*W-1:0] skew_a(logic [N*N*W-1:0] m, int t);
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) v[i*W +: W] = el(m, i, t - i);
    return v;
  endfunction

  function automatic logic [N*W-1:0] skew_b(logic [N*N*W-1:0] m, int t);
    logic [N*W-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) v[j*W +: W] = el(m, t - j, j);
    return v;
  endfunction

  function automatic logic [N*N*W-1:0] rand_mat();
    logic [N*N*W-1:0] m;
    for (int k = 0; k < N*N; k++) m[k*W +: W] = W'($urandom);
    return m;
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic [2:0] exp);
    check(tag, {61'd0, bus.o_busy, bus.o_done, bus.o_doProcess}, {61'd0, exp});
  endtask

  // mode 0: plain + start poke in DONE; 1: skew constants; 2: start/ack pokes in RUN;
  // 3: input matrices scrambled every RUN cycle.
  task automatic run_mult(input string name, input logic [N*N*W-1:0] ma,
                          input logic [N*N*W-1:0] mb, input int mode);
    int sum;
    for (int t = 0; t < STEPS; t++) begin
      q_a.push_back(skew_a(ma, t));
      q_b.push_back(skew_b(mb, t));
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        sum = 0;
        for (int k = 0; k < N; k++) sum += int'(el(ma, r, k)) * int'(el(mb, k, c));
        q_c.push_back(sum);
      end
    end

    bus.i_matA  = ma;
    bus.i_matB  = mb;
    bus.i_start = 1'b1;
    advance();
    bus.i_start = 1'b0;

    for (int t = 0; t < STEPS; t++) begin
      check($sformatf("%s_oa_t%0d", name, t), {32'd0, bus.o_a}, {32'd0, q_a.pop_front()});
      check($sformatf("%s_ob_t%0d", name, t), {32'd0, bus.o_b}, {32'd0, q_b.pop_front()});
      check_flags($sformatf("%s_flags_t%0d", name, t), 3'b101);
      if (mode == 1 && t == 3) check("skew_t3_rows", {32'd0, bus.o_a}, 64'h30211203);
      if (mode == 1 && t == 4) check("skew_t4_row0", {56'd0, bus.o_a[W-1:0]}, 64'd0);
      if (mode == 2) begin
        bus.i_start = (t == 2 || t == 6);
        bus.i_ack   = (t == 4 || t == 7);
        bus.i_matA  = ~ma;
        bus.i_matB  = ~mb;
      end
      if (mode == 3) begin
        bus.i_matA = rand_mat();
        bus.i_matB = rand_mat();
      end
      advance();
    end
    bus.i_start = 1'b0;
    bus.i_ack   = 1'b0;

    check_flags($sformatf("%s_done_flags", name), 3'b111);
    check($sformatf("%s_done_ops", name), {bus.o_a, bus.o_b}, 64'd0);

    if (mode == 0) begin
      bus.i_matA  = rand_mat();
      bus.i_start = 1'b1;
      advance();
      bus.i_start = 1'b0;
      check_flags($sformatf("%s_start_in_done", name), 3'b111);
    end
    advance();

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        check($sformatf("%s_pe%0d%0d", name, r, c), 64'(acc[r][c]), 64'(q_c.pop_front()));
    $display("[TB] %s: multiply complete, array results compared", name);
  endtask

  task automatic ack_done(input string name);
    bus.i_ack = 1'b1;
    advance();
    bus.i_ack = 1'b0;
    check_flags($sformatf("%s_after_ack", name), 3'b000);
    advance();
  endtask

  logic [N*N*W-1:0] ma, mb;

  initial begin
    bus.i_start = 1'b0;
    bus.i_ack   = 1'b0;
    bus.i_matA  = '0;
    bus.i_matB  = '0;

    repeat (3) advance();
    check("reset_ops", {bus.o_a, bus.o_b}, 64'd0);
    check_flags("reset_flags", 3'b000);
    arst = 1'b0;
    bus.i_ack = 1'b1;
    advance();
    bus.i_ack = 1'b0;
    check_flags("idle_ack_ignored", 3'b000);

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[(r*N + c)*W +: W] = (r == c) ? W'(1) : W'(0);
        mb[(r*N + c)*W +: W] = W'(r*4 + c + 1);
      end
    run_mult("identity", ma, mb, 0);
    ack_done("identity");

    run_mult("all_ff", {N*N*W{1'b1}}, {N*N*W{1'b1}}, 0);
    check("all_ff_pe33", 64'(acc[N-1][N-1]), 64'd260100);
    ack_done("all_ff");

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) ma[(r*N + c)*W +: W] = W'(16*r + c);
    run_mult("skew", ma, rand_mat(), 1);
    ack_done("skew");

    run_mult("pokes", rand_mat(), rand_mat(), 2);
    ack_done("pokes");

    run_mult("scramble", rand_mat(), rand_mat(), 3);
    ack_done("scramble");

    bus.i_matA  = rand_mat();
    bus.i_matB  = rand_mat();
    bus.i_start = 1'b1;
    advance();
    bus.i_start = 1'b0;
    repeat (5) advance();
    check_flags("abort_pre", 3'b101);
    arst = 1'b1;
    advance();
    check("abort_ops", {bus.o_a, bus.o_b}, 64'd0);
    check_flags("abort_flags", 3'b000);
    arst = 1'b0;
    advance();
    check_flags("abort_idle", 3'b000);
    $display("[TB] abort: reset applied at RUN step 5");
    run_mult("post_abort", rand_mat(), rand_mat(), 0);
    ack_done("post_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter N, default 4, meaning the array dimension (N x N PEs); legal range 2..16.
REQ-002 Parameter W, default 8, meaning the operand element width in bits; it matches the PE operand width.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_arst  input  1  reset; synchronous, active-high.
REQ-005 i_start  input  1  request to begin one matrix multiply; sampled only in IDLE.
REQ-006 i_matA  input  N*N*W  matrix A, row-major; element [r][c] at bits (r*N+c)*W +: W.
REQ-007 i_matB  input  N*N*W  matrix B, same packing as A.
REQ-008 i_ack  input  1  consumer has read results; sampled only in DONE.
REQ-009 o_a  output  N*W  left-edge operand per array row; row i at bits i*W +: W.
REQ-010 o_b  output  N*W  top-edge operand per array column; column j at bits j*W +: W.
REQ-011 o_doProcess  output  1  drives every PE doProcess input.
REQ-012 o_busy  output  1  high in RUN and DONE.
REQ-013 o_done  output  1  high in DONE; array results are valid and stable.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 IDLE -> RUN on i_start=1; A and B SHALL be captured into internal registers on that same edge, and the step counter t SHALL be cleared to 0.
REQ-016 RUN SHALL last exactly 3N-2 cycles (t = 0..3N-3) and then go to DONE; t SHALL increment by 1 each RUN cycle.
REQ-017 In RUN step t, row i of o_a SHALL equal Areg[i][t-i] when 0 <= t-i < N, and 0 otherwise.
REQ-018 In RUN step t, column j of o_b SHALL equal Breg[t-j][j] when 0 <= t-j < N, and 0 otherwise.
REQ-019 o_a, o_b and o_doProcess SHALL be register outputs with no combinational path from any input.
REQ-020 o_doProcess SHALL be 1 in RUN and DONE, and 0 in IDLE, so the array accumulates during RUN, holds during DONE, and clears in IDLE.
REQ-021 In DONE, o_a and o_b SHALL be all-zero, so accumulators stay constant.
REQ-022 DONE -> IDLE on i_ack=1; i_ack outside DONE SHALL be ignored.
REQ-023 i_start outside IDLE SHALL be ignored; the captured matrices SHALL NOT change until the next accepted start.
REQ-024 Simultaneous i_start and i_ack SHALL be resolved by the current state alone: only the input relevant to that state acts.
REQ-025 Changes on i_matA and i_matB after capture SHALL have no effect on o_a or o_b.
REQ-026 The counter SHALL be clog2(3N-1) bits wide and SHALL NOT wrap during RUN.
REQ-027 Operands SHALL pass through unchanged (no sign or width conversion).

Reset
REQ-028 On i_arst=1 at a clock edge, the state SHALL be IDLE and o_a, o_b, o_doProcess, o_busy, o_done, t, Areg and Breg SHALL all be 0.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abort the operation with the same result as REQ-028; the first cycle after reset deassertion SHALL be IDLE.
REQ-030 Reset SHALL take priority over i_start and i_ack.

Structure
REQ-031 Package systolic_pkg SHALL hold W, the default N, and the state enum type for IDLE, RUN and DONE.
REQ-032 The block SHALL be a single module with no sub-modules; the skew selection SHALL be a generate loop over rows and columns.

Verification
REQ-033 N=4, A=I, B[r][c]=r*4+c+1, pulse start -> 10 RUN cycles; a 4x4 pe array attached to the outputs SHALL hold C=B in DONE.
REQ-034 N=4, all-0xFF A and B -> every PE result SHALL be 4*255*255=260100 in DONE; o_done SHALL rise exactly 10 cycles after the start-capture edge.
REQ-035 Skew check with A[i][k]=16*i+k: at step t=3, o_a rows 0..3 SHALL be 0x03, 0x12, 0x21, 0x30; at step t=4, row 0 SHALL be 0.
REQ-036 Assert reset at RUN step 5 -> next cycle IDLE, all outputs 0; a new start then SHALL produce a correct full result.
REQ-037 i_start pulsed in RUN and DONE, and i_ack pulsed in RUN -> no state change and results unchanged; i_ack in DONE -> IDLE with o_doProcess=0 on the next cycle.
REQ-038 Change i_matA every cycle during RUN -> o_a SHALL match the matrix captured at start only.
